// File: rtl/shift_add_ctrl_pkg.sv
// rtl/shift_add_ctrl_pkg.sv - shared types and constants for the shift-and-add multiplier controller
package shift_add_ctrl_pkg;

  localparam int N_ITER    = 8;
  localparam int WIDTH_DEF = N_ITER;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/shift_add_dp.sv
// rtl/shift_add_dp.sv - operand registers, 9-bit adder and right shifter of the shift-and-add multiplier
module shift_add_dp #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift_en,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   addend,
  output logic [WIDTH-1:0]   mcand_q,
  output logic               mq_lsb,
  output logic [2*WIDTH-1:0] product
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH:0]   sum;

  // Keep the carry so the shifted-in MSB of acc is never lost.
  assign sum = {1'b0, acc} + {1'b0, addend};

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      acc     <= '0;
      mq      <= '0;
    end else if (load) begin
      mcand_q <= multiplicand;
      acc     <= '0;
      mq      <= multiplier;
    end else if (shift_en) begin
      acc <= sum[WIDTH:1];
      mq  <= {sum[0], mq[WIDTH-1:1]};
    end
  end

  assign mq_lsb  = mq[0];
  assign product = {acc, mq};

endmodule

// File: rtl/shift_add_ctrl.sv
// rtl/shift_add_ctrl.sv - sequencing FSM and iteration counter driving the external 2:1 addend mux
module shift_add_ctrl
  import shift_add_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [WIDTH-1:0]   mcand_q,
  output logic               mux_sel,
  input  logic [WIDTH-1:0]   addend,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          load;
  logic          shift_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (load)
        cnt <= '0;
      else if (shift_en)
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift_en  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        shift_en = 1'b1;
        if (cnt == LAST)
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pure state decodes: no combinational path from start to these outputs.
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  shift_add_dp #(.WIDTH(WIDTH)) u_dp (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .shift_en     (shift_en),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .addend       (addend),
    .mcand_q      (mcand_q),
    .mq_lsb       (mux_sel),
    .product      (product)
  );

endmodule

// File: tb/tb_shift_add_ctrl.sv
// tb/tb_shift_add_ctrl.sv - scoreboard bench for shift_add_ctrl with a behavioural 2:1 addend mux
module tb_shift_add_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic [7:0]  mcand_q;
  logic        mux_sel;
  logic [7:0]  addend;
  logic [15:0] product;
  logic        busy;
  logic        done;

  int          n_vec  = 0;
  int          n_err  = 0;
  int          n_done = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_p;

  always #5 clk = ~clk;

  assign addend = mux_sel ? mcand_q : 8'h00;

  shift_add_ctrl #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .mcand_q      (mcand_q),
    .mux_sel      (mux_sel),
    .addend       (addend),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_done++;
      chk("done_has_expect", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        exp_p = exp_q.pop_front();
        chk("product", 32'(product), 32'(exp_p));
      end
    end
  end

  task automatic check_idle_zero(input string tag);
    chk({tag, "_mcand_q"}, 32'(mcand_q), 0);
    chk({tag, "_mux_sel"}, 32'(mux_sel), 0);
    chk({tag, "_product"}, 32'(product), 0);
    chk({tag, "_busy"},    32'(busy),    0);
    chk({tag, "_done"},    32'(done),    0);
  endtask

  task automatic run_mult(input logic [7:0] a, input logic [7:0] b,
                          output int done_edge, output int busy_cycles, output bit sel_seen);
    @(negedge clk);
    start = 1'b1; multiplicand = a; multiplier = b;
    exp_q.push_back(16'(a) * 16'(b));
    @(posedge clk); #1;
    start = 1'b0;
    done_edge = -1; busy_cycles = 0; sel_seen = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (mux_sel) sel_seen = 1'b1;
      if (done) begin
        done_edge = k;
        break;
      end
    end
    chk("done_latency", 32'(done_edge), 8);
    @(negedge clk);
    chk("done_single", 32'(done), 0);
    chk("busy_after", 32'(busy), 0);
    chk("product_hold", 32'(product), 32'(16'(a) * 16'(b)));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  de, bc, d0, first, second;
    bit  ss;
    rst = 1'b1; start = 1'b0; multiplicand = 8'h00; multiplier = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_zero("reset");

    run_mult(8'd13, 8'd11, de, bc, ss);
    chk("busy_cycles_13x11", 32'(bc), 9);
    run_mult(8'd255, 8'd255, de, bc, ss);
    run_mult(8'd0, 8'd200, de, bc, ss);
    run_mult(8'd200, 8'd0, de, bc, ss);
    chk("mux_sel_200x0", 32'(ss), 0);
    run_mult(8'd173, 8'd94, de, bc, ss);

    // Second start during RUN must be ignored.
    @(negedge clk);
    start = 1'b1; multiplicand = 8'd3; multiplier = 8'd4;
    exp_q.push_back(16'h000C);
    @(posedge clk); #1 start = 1'b0;
    d0 = n_done;
    repeat (3) @(negedge clk);
    start = 1'b1; multiplicand = 8'd5; multiplier = 8'd6;
    @(posedge clk); #1 start = 1'b0;
    repeat (14) @(negedge clk);
    chk("ignored_start_dones", 32'(n_done - d0), 1);
    chk("ignored_start_hold", 32'(product), 32'h000C);

    // Reset mid-RUN drops the operation.
    @(negedge clk);
    start = 1'b1; multiplicand = 8'd9; multiplier = 8'd9;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_idle_zero("midrun_rst");
    d0 = n_done;
    repeat (12) @(negedge clk);
    chk("midrun_rst_no_done", 32'(n_done - d0), 0);
    run_mult(8'd7, 8'd9, de, bc, ss);

    // start held high: re-accepted one cycle after DONE.
    @(negedge clk);
    start = 1'b1; multiplicand = 8'd2; multiplier = 8'd5;
    exp_q.push_back(16'h000A);
    exp_q.push_back(16'h000A);
    @(posedge clk); #1;
    first = -1; second = -1;
    for (int k = 0; k <= 30; k++) begin
      @(negedge clk);
      if (done) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
      if (second >= 0) begin
        start = 1'b0;
        break;
      end
    end
    start = 1'b0;
    chk("held_first_done", 32'(first), 8);
    chk("held_second_done", 32'(second), 18);
    @(negedge clk);
    chk("held_busy_after", 32'(busy), 0);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
